chain_search: RTL and testbench
===============================

# chain_search

Search stage directly downstream of the bucket head-pointer lookup. It accepts one packet per command carrying the key, bucket, head pointer and head-valid flag. It walks that bucket's linked chain in the data RAM through a 1-cycle-latency read port, compares each entry's key against the command key, and returns one result per command over a valid/ready handshake. Only one command is in flight at a time.

## Interface
- KEY_WIDTH, 32: key width; must match `ht_pdata_t.cmd.key`.
- VALUE_WIDTH, 32: stored value width.
- PTR_WIDTH, 10: data RAM address/pointer width.
- MAX_CHAIN, 16: maximum entries read per command before aborting the walk.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- pdata_in_i  in  $bits(ht_pdata_t)  command packet: cmd.opcode, cmd.key, bucket, head_ptr, head_ptr_val.
- pdata_in_valid_i  in  1  input valid.
- pdata_in_ready_o  out  1  input ready.
- rd_addr_o  out  PTR_WIDTH  data RAM read address.
- rd_en_o  out  1  data RAM read enable.
- rd_data_i  in  $bits(ht_data_ram_t)  RAM word (key, value, next_ptr, next_ptr_val); valid the cycle after rd_en_o.
- result_o  out  $bits(ht_result_t)  cmd, bucket, rescode, value, chain_len.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result ready.

## Operation
- FSM states: IDLE, CHECK, OUT.
- IDLE:
  - pdata_in_ready_o = 1.
  - On handshake, latch the packet and clear chain_cnt.
  - If opcode != OP_SEARCH: go to OUT, rescode = RES_ILLEGAL_OP, no RAM read.
  - Else if head_ptr_val = 0: go to OUT, rescode = RES_NO_ENTRY, chain_len = 0.
  - Else: rd_en_o = 1, rd_addr_o = pdata_in_i.head_ptr in the same cycle (combinational from the input), chain_cnt <= 1, go to CHECK.
- CHECK (rd_data_i valid):
  - If rd_data_i.key == latched key: rescode = RES_FOUND, value = rd_data_i.value, go to OUT.
  - Else if next_ptr_val = 0: rescode = RES_NOT_FOUND, go to OUT.
  - Else if chain_cnt == MAX_CHAIN: rescode = RES_CHAIN_LIMIT, go to OUT, no read.
  - Else: rd_en_o = 1, rd_addr_o = rd_data_i.next_ptr, chain_cnt++, stay in CHECK.
- OUT:
  - result_valid_o = 1; result_o is registered and held stable until the handshake.
  - On result_ready_i go to IDLE.
  - pdata_in_ready_o = 0 outside IDLE.
- chain_len = chain_cnt, the number of RAM reads performed. Counter width is $clog2(MAX_CHAIN+1); it never wraps.
- The key compare is full-width equality; value and pointer fields are ignored in the compare.
- rd_en_o = 0 in every case not listed above.
- rd_addr_o = 0 whenever rd_en_o = 0, so the RAM port does not toggle.
- The block never writes the RAM. Concurrent insert/delete coherency is the dispatcher's responsibility.

## Timing
- Reset (rst_ni low, asynchronous):
  - state = IDLE, chain_cnt = 0.
  - result_valid_o = 0, result_o = 0, rd_en_o = 0, rd_addr_o = 0.
  - pdata_in_ready_o = 1 (IDLE) once rst_ni deasserts; inputs are ignored while rst_ni is low.
- Input handshake at cycle 0. With a hit at the Nth entry, result_valid_o rises in cycle N+1.
- Empty bucket or illegal opcode: result_valid_o rises in cycle 1.
- Miss or chain limit after N reads: result_valid_o rises in cycle N+1.
- Throughput: the next command is accepted no earlier than the cycle after the result handshake. There is no overlap.
- Reset mid-walk drops the command: no result, rd_en_o drops to 0 immediately.
- If result_ready_i is held low, the FSM stays in OUT indefinitely with all outputs stable.

## Structure
- hash_table package adds:
  - ht_data_ram_t {key, value, next_ptr, next_ptr_val}.
  - ht_rescode_t enum {RES_FOUND, RES_NOT_FOUND, RES_NO_ENTRY, RES_CHAIN_LIMIT, RES_ILLEGAL_OP}.
  - ht_result_t {cmd, bucket, rescode, value, chain_len}.
- The FSM-state enum stays local to the module.
- Single module, no sub-modules. The RAM is instantiated outside and shared with the data-table writer.

## Test plan
- Empty bucket: head_ptr_val = 0, key 0x11 -> RES_NO_ENTRY and chain_len 0 in cycle 1, zero rd_en_o pulses.
- Hit at head: head = 5, RAM[5].key = 0x11, value 0xAB -> rd_addr 5 in cycle 0, RES_FOUND with value 0xAB in cycle 2.
- Hit at third entry: chain 5->9->3, RAM[3].key = 0x11, value 0xCD -> reads 5, 9, 3 in consecutive cycles, RES_FOUND with value 0xCD, chain_len 3, in cycle 4.
- Miss, plus illegal opcode: chain 5->9 ending (next_ptr_val = 0), no match -> RES_NOT_FOUND, chain_len 2. An OP_INSERT command -> RES_ILLEGAL_OP, no reads.
- Loop guard: RAM[7].next_ptr = 7, key mismatch -> exactly 16 reads, then RES_CHAIN_LIMIT with chain_len 16.
- Backpressure and reset: result_ready_i low for 5 cycles -> result_o stable and pdata_in_ready_o = 0 throughout. rst_ni pulsed low mid-walk -> no result, state IDLE, next command processed correctly.

Source files
------------

// File: rtl/chain_search_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | chain_search_pkg: hash-table command, data-RAM and result types.          |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package chain_search_pkg;

  localparam int HT_KEY_WIDTH    = 32;
  localparam int HT_VALUE_WIDTH  = 32;
  localparam int HT_PTR_WIDTH    = 10;
  localparam int HT_BUCKET_WIDTH = 8;
  localparam int HT_MAX_CHAIN    = 16;
  localparam int HT_CNT_WIDTH    = $clog2(HT_MAX_CHAIN + 1);

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t                opcode;
    logic [HT_KEY_WIDTH-1:0]   key;
  } ht_cmd_t;

  typedef struct packed {
    ht_cmd_t                    cmd;
    logic [HT_BUCKET_WIDTH-1:0] bucket;
    logic [HT_PTR_WIDTH-1:0]    head_ptr;
    logic                       head_ptr_val;
  } ht_pdata_t;

  typedef struct packed {
    logic [HT_KEY_WIDTH-1:0]   key;
    logic [HT_VALUE_WIDTH-1:0] value;
    logic [HT_PTR_WIDTH-1:0]   next_ptr;
    logic                      next_ptr_val;
  } ht_data_ram_t;

  typedef enum logic [2:0] {
    RES_FOUND       = 3'd0,
    RES_NOT_FOUND   = 3'd1,
    RES_NO_ENTRY    = 3'd2,
    RES_CHAIN_LIMIT = 3'd3,
    RES_ILLEGAL_OP  = 3'd4
  } ht_rescode_t;

  typedef struct packed {
    ht_cmd_t                    cmd;
    logic [HT_BUCKET_WIDTH-1:0] bucket;
    ht_rescode_t                rescode;
    logic [HT_VALUE_WIDTH-1:0]  value;
    logic [HT_CNT_WIDTH-1:0]    chain_len;
  } ht_result_t;

endpackage
`default_nettype wire

// File: rtl/chain_search.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | chain_search: walks one bucket's linked chain per command, returns result.|
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module chain_search
  import chain_search_pkg::*;
#(
  parameter int KEY_WIDTH   = HT_KEY_WIDTH,
  parameter int VALUE_WIDTH = HT_VALUE_WIDTH,
  parameter int PTR_WIDTH   = HT_PTR_WIDTH,
  parameter int MAX_CHAIN   = HT_MAX_CHAIN
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  ht_pdata_t            pdata_in_i,
  input  logic                 pdata_in_valid_i,
  output logic                 pdata_in_ready_o,
  output logic [PTR_WIDTH-1:0] rd_addr_o,
  output logic                 rd_en_o,
  input  ht_data_ram_t         rd_data_i,
  output ht_result_t           result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i
);

  localparam int                   CNT_WIDTH = $clog2(MAX_CHAIN + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_CHAIN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] chain_cnt_q, chain_cnt_d;
  ht_result_t           result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 rd_en;
  logic [PTR_WIDTH-1:0] rd_addr;

  logic [KEY_WIDTH-1:0]   ram_key;
  logic [KEY_WIDTH-1:0]   cmd_key;
  logic [VALUE_WIDTH-1:0] ram_value;
  logic [PTR_WIDTH-1:0]   ram_next;
  logic [PTR_WIDTH-1:0]   head_ptr;

  assign ram_key   = rd_data_i.key;
  assign ram_value = rd_data_i.value;
  assign ram_next  = rd_data_i.next_ptr;
  assign head_ptr  = pdata_in_i.head_ptr;
  // The latched command lives in the result register for the whole walk.
  assign cmd_key   = result_q.cmd.key;

  always_comb begin
    state_d        = state_q;
    chain_cnt_d    = chain_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    rd_en          = 1'b0;
    rd_addr        = '0;

    case (state_q)
      ST_IDLE: begin
        if (pdata_in_valid_i) begin
          chain_cnt_d     = '0;
          result_d        = '0;
          result_d.cmd    = pdata_in_i.cmd;
          result_d.bucket = pdata_in_i.bucket;
          if (pdata_in_i.cmd.opcode != OP_SEARCH) begin
            result_d.rescode = RES_ILLEGAL_OP;
            result_valid_d   = 1'b1;
            state_d          = ST_OUT;
          end else if (!pdata_in_i.head_ptr_val) begin
            result_d.rescode = RES_NO_ENTRY;
            result_valid_d   = 1'b1;
            state_d          = ST_OUT;
          end else begin
            rd_en       = 1'b1;
            rd_addr     = head_ptr;
            chain_cnt_d = CNT_WIDTH'(1);
            state_d     = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        result_d.chain_len = chain_cnt_q;
        if (ram_key == cmd_key) begin
          result_d.rescode = RES_FOUND;
          result_d.value   = ram_value;
          result_valid_d   = 1'b1;
          state_d          = ST_OUT;
        end else if (!rd_data_i.next_ptr_val) begin
          result_d.rescode = RES_NOT_FOUND;
          result_valid_d   = 1'b1;
          state_d          = ST_OUT;
        end else if (chain_cnt_q == CNT_MAX) begin
          result_d.rescode = RES_CHAIN_LIMIT;
          result_valid_d   = 1'b1;
          state_d          = ST_OUT;
        end else begin
          rd_en       = 1'b1;
          rd_addr     = ram_next;
          chain_cnt_d = chain_cnt_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (result_ready_i) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: begin
        result_valid_d = 1'b0;
        state_d        = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      chain_cnt_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chain_cnt_q    <= chain_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Gating with rst_ni keeps the RAM port quiet and the input closed while reset is held.
  assign rd_en_o          = rd_en & rst_ni;
  assign rd_addr_o        = rd_en_o ? rd_addr : '0;
  assign pdata_in_ready_o = (state_q == ST_IDLE) & rst_ni;
  assign result_o         = result_q;
  assign result_valid_o   = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_search.sv
`default_nettype none
// tb_chain_search: directed table, corner sequences and randomized runs against a chain-walk model.
module tb_chain_search;
  import chain_search_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  ht_pdata_t    pdata_in = '0;
  logic         pdata_valid = 1'b0;
  logic         pdata_ready;
  logic [HT_PTR_WIDTH-1:0] rd_addr;
  logic         rd_en;
  ht_data_ram_t rd_data = '0;
  ht_result_t   result;
  logic         result_valid;
  logic         result_ready = 1'b0;

  ht_data_ram_t ram [0:(1<<HT_PTR_WIDTH)-1];
  int checks = 0;
  int failures = 0;

  logic [HT_PTR_WIDTH-1:0] addr_log[$];
  int                      cyc_log[$];
  logic [HT_PTR_WIDTH-1:0] exp_addrs[$];

  chain_search dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pdata_in_i       (pdata_in),
    .pdata_in_valid_i (pdata_valid),
    .pdata_in_ready_o (pdata_ready),
    .rd_addr_o        (rd_addr),
    .rd_en_o          (rd_en),
    .rd_data_i        (rd_data),
    .result_o         (result),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready)
  );

  always #5 clk = ~clk;

  // One-cycle-latency read port.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  typedef struct packed {
    ht_opcode_t                          op;
    logic [31:0]                         key;
    logic [HT_PTR_WIDTH-1:0]             head;
    logic                                hv;
    logic [1:0]                          nw;
    logic [2:0][HT_PTR_WIDTH-1:0]        waddr;
    ht_data_ram_t [2:0]                  wdata;
    ht_rescode_t                         exp_rc;
    logic [31:0]                         exp_val;
    logic [4:0]                          exp_len;
    logic [4:0]                          exp_lat;
  } vec_t;

  vec_t vecs [6];

  function automatic ht_data_ram_t mk(input logic [31:0] k, input logic [31:0] v,
                                      input int nxt, input logic nv);
    ht_data_ram_t w;
    w.key = k; w.value = v; w.next_ptr = HT_PTR_WIDTH'(nxt); w.next_ptr_val = nv;
    return w;
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < (1<<HT_PTR_WIDTH); i++) ram[i] = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Chain walk straight from the behavioural rules: read, compare, follow, stop at the cap.
  function automatic void model(input ht_pdata_t p, output ht_rescode_t rc,
                                output logic [31:0] val, output int len, output int lat);
    logic [HT_PTR_WIDTH-1:0] ptr;
    ht_data_ram_t w;
    exp_addrs.delete();
    val = '0; len = 0; lat = 1;
    if (p.cmd.opcode != OP_SEARCH) begin rc = RES_ILLEGAL_OP; return; end
    if (!p.head_ptr_val) begin rc = RES_NO_ENTRY; return; end
    rc  = RES_CHAIN_LIMIT;
    ptr = p.head_ptr;
    for (int i = 1; i <= HT_MAX_CHAIN; i++) begin
      exp_addrs.push_back(ptr);
      len = i;
      w = ram[ptr];
      if (w.key == p.cmd.key) begin rc = RES_FOUND; val = w.value; break; end
      if (!w.next_ptr_val) begin rc = RES_NOT_FOUND; break; end
      ptr = w.next_ptr;
    end
    lat = len + 1;
  endfunction

  task automatic sample_reads(input int c);
    if (rd_en) begin
      addr_log.push_back(rd_addr);
      cyc_log.push_back(c);
    end else begin
      chk("rd_addr_idle_zero", 64'(rd_addr), 64'd0);
    end
  endtask

  task automatic run_cmd(input string tag, input ht_pdata_t p, input int hold,
                         output ht_result_t res, output int lat);
    int n;
    addr_log.delete(); cyc_log.delete();
    @(negedge clk); pdata_in = p; pdata_valid = 1'b1; #1;
    chk({tag, ":in_ready"}, 64'(pdata_ready), 64'd1);
    sample_reads(0);
    @(negedge clk); pdata_valid = 1'b0; pdata_in = '0; #1;
    n = 1;
    while (!result_valid && n < 64) begin
      chk({tag, ":in_ready_busy"}, 64'(pdata_ready), 64'd0);
      sample_reads(n);
      @(negedge clk); #1; n++;
    end
    chk({tag, ":result_valid_timeout"}, 64'(result_valid), 64'd1);
    chk({tag, ":rd_en_in_out"}, 64'(rd_en), 64'd0);
    lat = n;
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({tag, ":hold_result"}, 64'(result), 64'(res));
      chk({tag, ":hold_valid"}, 64'(result_valid), 64'd1);
      chk({tag, ":hold_in_ready"}, 64'(pdata_ready), 64'd0);
      chk({tag, ":hold_rd_en"}, 64'(rd_en), 64'd0);
    end
    result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0; #1;
    chk({tag, ":valid_drop"}, 64'(result_valid), 64'd0);
    chk({tag, ":ready_back"}, 64'(pdata_ready), 64'd1);
  endtask

  task automatic compare(input string tag, input ht_pdata_t p, input ht_result_t res,
                         input int lat, input ht_rescode_t rc, input logic [31:0] val,
                         input int len, input int elat);
    chk({tag, ":rescode"}, 64'(res.rescode), 64'(rc));
    chk({tag, ":chain_len"}, 64'(res.chain_len), 64'(len));
    chk({tag, ":latency"}, 64'(lat), 64'(elat));
    chk({tag, ":cmd"}, 64'(res.cmd), 64'(p.cmd));
    chk({tag, ":bucket"}, 64'(res.bucket), 64'(p.bucket));
    if (rc == RES_FOUND) chk({tag, ":value"}, 64'(res.value), 64'(val));
    chk({tag, ":n_reads"}, 64'(addr_log.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < addr_log.size() && i < exp_addrs.size(); i++) begin
      chk({tag, ":read_addr"}, 64'(addr_log[i]), 64'(exp_addrs[i]));
      chk({tag, ":read_cycle"}, 64'(cyc_log[i]), 64'(i));
    end
  endtask

  initial begin
    ht_pdata_t   p;
    ht_result_t  res;
    int          lat, mlen, mlat;
    ht_rescode_t mrc;
    logic [31:0] mval;

    // Directed table from the test plan.
    vecs[0] = '0; vecs[0].op = OP_SEARCH; vecs[0].key = 32'h11; vecs[0].hv = 1'b0;
    vecs[0].exp_rc = RES_NO_ENTRY; vecs[0].exp_len = 5'd0; vecs[0].exp_lat = 5'd1;

    vecs[1] = '0; vecs[1].op = OP_SEARCH; vecs[1].key = 32'h11; vecs[1].head = 10'd5; vecs[1].hv = 1'b1;
    vecs[1].nw = 2'd1; vecs[1].waddr[0] = 10'd5; vecs[1].wdata[0] = mk(32'h11, 32'hAB, 0, 1'b0);
    vecs[1].exp_rc = RES_FOUND; vecs[1].exp_val = 32'hAB; vecs[1].exp_len = 5'd1; vecs[1].exp_lat = 5'd2;

    vecs[2] = '0; vecs[2].op = OP_SEARCH; vecs[2].key = 32'h11; vecs[2].head = 10'd5; vecs[2].hv = 1'b1;
    vecs[2].nw = 2'd3;
    vecs[2].waddr[0] = 10'd5; vecs[2].wdata[0] = mk(32'h22, 32'h1, 9, 1'b1);
    vecs[2].waddr[1] = 10'd9; vecs[2].wdata[1] = mk(32'h33, 32'h2, 3, 1'b1);
    vecs[2].waddr[2] = 10'd3; vecs[2].wdata[2] = mk(32'h11, 32'hCD, 0, 1'b0);
    vecs[2].exp_rc = RES_FOUND; vecs[2].exp_val = 32'hCD; vecs[2].exp_len = 5'd3; vecs[2].exp_lat = 5'd4;

    vecs[3] = '0; vecs[3].op = OP_SEARCH; vecs[3].key = 32'h11; vecs[3].head = 10'd5; vecs[3].hv = 1'b1;
    vecs[3].nw = 2'd2;
    vecs[3].waddr[0] = 10'd5; vecs[3].wdata[0] = mk(32'h22, 32'h1, 9, 1'b1);
    vecs[3].waddr[1] = 10'd9; vecs[3].wdata[1] = mk(32'h33, 32'h2, 0, 1'b0);
    vecs[3].exp_rc = RES_NOT_FOUND; vecs[3].exp_len = 5'd2; vecs[3].exp_lat = 5'd3;

    vecs[4] = '0; vecs[4].op = OP_INSERT; vecs[4].key = 32'h11; vecs[4].head = 10'd5; vecs[4].hv = 1'b1;
    vecs[4].nw = 2'd1; vecs[4].waddr[0] = 10'd5; vecs[4].wdata[0] = mk(32'h11, 32'hAB, 0, 1'b0);
    vecs[4].exp_rc = RES_ILLEGAL_OP; vecs[4].exp_len = 5'd0; vecs[4].exp_lat = 5'd1;

    vecs[5] = '0; vecs[5].op = OP_SEARCH; vecs[5].key = 32'h11; vecs[5].head = 10'd7; vecs[5].hv = 1'b1;
    vecs[5].nw = 2'd1; vecs[5].waddr[0] = 10'd7; vecs[5].wdata[0] = mk(32'h99, 32'h5, 7, 1'b1);
    vecs[5].exp_rc = RES_CHAIN_LIMIT; vecs[5].exp_len = 5'd16; vecs[5].exp_lat = 5'd17;

    clear_ram();

    // Reset state, with a live-looking command present that must be ignored.
    pdata_in = '0; pdata_in.cmd.opcode = OP_SEARCH; pdata_in.head_ptr = 10'd5; pdata_in.head_ptr_val = 1'b1;
    pdata_valid = 1'b1;
    #12;
    chk("reset:result_valid", 64'(result_valid), 64'd0);
    chk("reset:result", 64'(result), 64'd0);
    chk("reset:rd_en", 64'(rd_en), 64'd0);
    chk("reset:rd_addr", 64'(rd_addr), 64'd0);
    chk("reset:in_ready_low", 64'(pdata_ready), 64'd0);
    pdata_valid = 1'b0; pdata_in = '0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("reset:in_ready_after", 64'(pdata_ready), 64'd1);

    for (int v = 0; v < 6; v++) begin
      clear_ram();
      for (int w = 0; w < int'(vecs[v].nw); w++) ram[vecs[v].waddr[w]] = vecs[v].wdata[w];
      p = '0;
      p.cmd.opcode = vecs[v].op; p.cmd.key = vecs[v].key; p.bucket = 8'(v + 3);
      p.head_ptr = vecs[v].head; p.head_ptr_val = vecs[v].hv;
      model(p, mrc, mval, mlen, mlat);
      run_cmd($sformatf("vec%0d", v), p, (v == 2) ? 5 : 0, res, lat);
      compare($sformatf("vec%0d", v), p, res, lat, vecs[v].exp_rc, vecs[v].exp_val,
              int'(vecs[v].exp_len), int'(vecs[v].exp_lat));
    end

    // Reset in the middle of a walk: command is dropped, port goes quiet at once.
    clear_ram();
    ram[7] = mk(32'h99, 32'h5, 7, 1'b1);
    @(negedge clk);
    pdata_in = '0; pdata_in.cmd.opcode = OP_SEARCH; pdata_in.cmd.key = 32'h11;
    pdata_in.head_ptr = 10'd7; pdata_in.head_ptr_val = 1'b1; pdata_valid = 1'b1;
    @(negedge clk); pdata_valid = 1'b0; pdata_in = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("midrst:walking", 64'(rd_en), 64'd1);
    rst_n = 1'b0; #1;
    chk("midrst:rd_en", 64'(rd_en), 64'd0);
    chk("midrst:rd_addr", 64'(rd_addr), 64'd0);
    chk("midrst:result_valid", 64'(result_valid), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst:idle_ready", 64'(pdata_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("midrst:no_result", 64'(result_valid), 64'd0);
      chk("midrst:no_read", 64'(rd_en), 64'd0);
    end
    clear_ram();
    ram[5] = mk(32'h11, 32'hAB, 0, 1'b0);
    p = '0; p.cmd.opcode = OP_SEARCH; p.cmd.key = 32'h11; p.bucket = 8'h42;
    p.head_ptr = 10'd5; p.head_ptr_val = 1'b1;
    model(p, mrc, mval, mlen, mlat);
    run_cmd("after_rst", p, 0, res, lat);
    compare("after_rst", p, res, lat, RES_FOUND, 32'hAB, 1, 2);

    // Randomized commands over a small RAM region so hits, misses and loops all occur.
    for (int it = 0; it < 40; it++) begin
      clear_ram();
      for (int a = 0; a < 32; a++)
        ram[a] = mk(32'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 31)),
                    1'($urandom_range(0, 3) != 0));
      p = '0;
      p.cmd.opcode = ($urandom_range(0, 7) == 0) ? ht_opcode_t'($urandom_range(1, 2)) : OP_SEARCH;
      p.cmd.key = 32'($urandom_range(0, 7));
      p.bucket = 8'($urandom);
      p.head_ptr = 10'($urandom_range(0, 31));
      p.head_ptr_val = 1'($urandom_range(0, 7) != 0);
      model(p, mrc, mval, mlen, mlat);
      run_cmd($sformatf("rand%0d", it), p, int'($urandom_range(0, 2)), res, lat);
      compare($sformatf("rand%0d", it), p, res, lat, mrc, mval, mlen, mlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
